alu_result_bcd: RTL

Sequential binary-to-BCD converter sitting directly downstream of the 8-bit accumulating ALU register. It captures the registered ALU result `q` on a start pulse and runs a shift-and-add-3 (double-dabble) conversion, one bit per clock. It then presents hundreds/tens/ones digits to the existing 4-bit hex/7-segment decoders, so the board shows the accumulator in decimal. It uses a start/busy/done handshake and holds its last result until the next conversion completes.

---
 rtl/alu_pkg.sv | 13 +
 rtl/bcd_digit_adjust.sv | 14 +
 rtl/alu_result_bcd.sv | 98 +++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared ALU / display constants and the BCD converter state encoding.
package alu_pkg;

  localparam int ALU_WIDTH  = 8;
  localparam int BCD_DIGITS = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } bcd_state_e;

endpackage

// File: rtl/bcd_digit_adjust.sv
// Double-dabble digit correction: add 3 to a BCD nibble holding 5..9 so the
// following left shift carries correctly into the next decimal digit.
module bcd_digit_adjust (
  input  logic [3:0] din,
  output logic [3:0] dout
);

  // 5..9 map to 8..12, never wrapping the nibble
  always_comb begin
    dout = din;
    if (din >= 4'd5) dout = din + 4'd3;
  end

endmodule

// File: rtl/alu_result_bcd.sv
// Sequential binary-to-BCD converter for the ALU accumulator display.
// One shift-and-add-3 step per clock; bcd holds until the next conversion ends.
module alu_result_bcd
  import alu_pkg::*;
#(
  parameter int WIDTH  = ALU_WIDTH,
  parameter int DIGITS = BCD_DIGITS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd
);

  localparam int SR_W  = 4*DIGITS + WIDTH;
  localparam int CNT_W = $clog2(WIDTH+1);

  bcd_state_e          state_q, state_d;
  logic [SR_W-1:0]     sr_q, sr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [4*DIGITS-1:0] bcd_q, bcd_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic [DIGITS-1:0][3:0] adj;
  logic [SR_W-1:0]        sr_adj;
  logic [SR_W-1:0]        sr_shift;
  logic                   last_shift;

  // every digit of the shift register is corrected in parallel
  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adjust u_adj (
      .din  (sr_q[WIDTH + 4*g +: 4]),
      .dout (adj[g])
    );
  end

  assign sr_adj     = {adj, sr_q[WIDTH-1:0]};
  assign sr_shift   = sr_adj << 1;
  assign last_shift = (cnt_q == CNT_W'(WIDTH-1));

  // next-state: load on start from IDLE/DONE, shift WIDTH times, publish on last
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          sr_d    = {{(4*DIGITS){1'b0}}, bin};
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        sr_d  = sr_shift;
        cnt_d = cnt_q + 1'b1;
        if (last_shift) begin
          bcd_d   = sr_shift[SR_W-1 -: 4*DIGITS];
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d == ST_SHIFT);
    done_d = (state_d == ST_DONE);
  end

  // state, datapath and registered handshake outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      bcd_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign bcd  = bcd_q;

endmodule
